// File: rtl/stage_1_dispatcher_pkg.sv
// rtl/stage_1_dispatcher_pkg.sv - shared state encodings, widths and float constants
//
// Purpose: common definitions for the stage-1 dispatcher, its interface,
// its result register and the benches that drive them.
package stage_1_dispatcher_pkg;

    localparam int FLT_DATA_WIDTH = 32;
    localparam int N_RESULTS      = 6;

    typedef logic [2:0] state_t;

    localparam state_t LOAD_ONE = 3'd0;
    localparam state_t LOAD_TWO = 3'd1;
    localparam state_t FIRE     = 3'd2;
    localparam state_t WAIT     = 3'd3;
    localparam state_t HOLD     = 3'd4;

    // Canonical IEEE-754 single-precision values.
    localparam logic [31:0] FLT_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FLT_HALF    = 32'h3F00_0000;
    localparam logic [31:0] FLT_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FLT_TWO     = 32'h4000_0000;
    localparam logic [31:0] FLT_NEG_ONE = 32'hBF80_0000;

endpackage

// File: rtl/stage_1_dispatcher_if.sv
// rtl/stage_1_dispatcher_if.sv - operand, stage-1 and result buses of the dispatcher
//
// Purpose: bundles the operand stream (in_*), the stage-1 start/done bus (s1_*),
// the result stream (res_*) and the status outputs (timeout, err_count, busy).
// Modports: master = dispatcher side, slave = environment side.
interface stage_1_dispatcher_if
    import stage_1_dispatcher_pkg::*;
#(
    parameter int W  = FLT_DATA_WIDTH,
    parameter int EW = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;

    logic         s1_start;
    logic [W-1:0] s1_x_one;
    logic [W-1:0] s1_x_two;
    logic         s1_done;
    logic [W-1:0] s1_out_one;
    logic [W-1:0] s1_out_two;
    logic [W-1:0] s1_half_one;
    logic [W-1:0] s1_half_two;
    logic [W-1:0] s1_square_one;
    logic [W-1:0] s1_square_two;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_out_one;
    logic [W-1:0] res_out_two;
    logic [W-1:0] res_half_one;
    logic [W-1:0] res_half_two;
    logic [W-1:0] res_square_one;
    logic [W-1:0] res_square_two;

    logic          timeout;
    logic [EW-1:0] err_count;
    logic          busy;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output s1_start, s1_x_one, s1_x_two,
        input  s1_done, s1_out_one, s1_out_two, s1_half_one, s1_half_two,
               s1_square_one, s1_square_two,
        output res_valid, res_out_one, res_out_two, res_half_one, res_half_two,
               res_square_one, res_square_two,
        input  res_ready,
        output timeout, err_count, busy
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  s1_start, s1_x_one, s1_x_two,
        output s1_done, s1_out_one, s1_out_two, s1_half_one, s1_half_two,
               s1_square_one, s1_square_two,
        input  res_valid, res_out_one, res_out_two, res_half_one, res_half_two,
               res_square_one, res_square_two,
        output res_ready,
        input  timeout, err_count, busy
    );

endinterface

// File: rtl/stage_1_result_reg.sv
// rtl/stage_1_result_reg.sv - six-word capture register with load and clear
//
// Purpose: holds the six stage-1 results between capture and hand-off.
// Ports: clk, rst (async active-low), clk_en (hold when low), load, clear
// (clear wins over load), d (six words in), q (six words out).
module stage_1_result_reg
    import stage_1_dispatcher_pkg::*;
#(
    parameter int W = FLT_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        load,
    input  logic                        clear,
    input  logic [N_RESULTS-1:0][W-1:0] d,
    output logic [N_RESULTS-1:0][W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clk_en) begin
            if (clear) begin
                q <= '0;
            end else if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/stage_1_dispatcher.sv
// rtl/stage_1_dispatcher.sv - pairs operands, runs the stage-1 start/done handshake, holds results
//
// Purpose: accepts two operands, pulses s1_start, waits for s1_done (with a
// timeout), captures the six results and offers them on res_valid/res_ready.
// Ports: clk, rst (async active-low), clk_en (global enable),
// bus (stage_1_dispatcher_if.master: in_*, s1_*, res_*, timeout, err_count, busy).
module stage_1_dispatcher
    import stage_1_dispatcher_pkg::*;
#(
    parameter int FLT_DATA_WIDTH = stage_1_dispatcher_pkg::FLT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ERR_WIDTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    stage_1_dispatcher_if.master   bus
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                                  state;
    state_t                                  state_nxt;
    logic [CW-1:0]                           wait_cnt;
    logic [FLT_DATA_WIDTH-1:0]               x_one;
    logic [FLT_DATA_WIDTH-1:0]               x_two;
    logic                                    res_valid;
    logic                                    timeout;
    logic [ERR_WIDTH-1:0]                    err_cnt;
    logic [N_RESULTS-1:0][FLT_DATA_WIDTH-1:0] s1_res;
    logic [N_RESULTS-1:0][FLT_DATA_WIDTH-1:0] res_q;

    logic done_hit;
    logic expire;

    // A done on the last counted cycle takes priority over the timeout.
    assign done_hit = (state == WAIT) && bus.s1_done;
    assign expire   = (state == WAIT) && !bus.s1_done && (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD_ONE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_ONE: if (bus.in_valid) state_nxt = LOAD_TWO;
            LOAD_TWO: if (bus.in_valid) state_nxt = FIRE;
            FIRE:     state_nxt = WAIT;
            WAIT: begin
                if (bus.s1_done) begin
                    state_nxt = HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = LOAD_ONE;
                end
            end
            HOLD:     if (bus.res_ready) state_nxt = LOAD_ONE;
            default:  state_nxt = LOAD_ONE;
        endcase
    end

    // State-decoded outputs; s1_start is a state decode so it stretches
    // naturally while clk_en is low.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.s1_start = 1'b0;
        bus.busy     = 1'b1;
        case (state)
            LOAD_ONE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            LOAD_TWO: bus.in_ready = 1'b1;
            FIRE:     bus.s1_start = 1'b1;
            default:  ;
        endcase
    end

    // Operand latches, wait counter, result handshake and error tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_one     <= '0;
            x_two     <= '0;
            wait_cnt  <= '0;
            res_valid <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= '0;
        end else if (clk_en) begin
            timeout <= expire;
            if ((state == LOAD_ONE) && bus.in_valid) begin
                x_one <= bus.in_data;
            end
            if ((state == LOAD_TWO) && bus.in_valid) begin
                x_two <= bus.in_data;
            end
            if (state == FIRE) begin
                wait_cnt <= '0;
            end else if ((state == WAIT) && !bus.s1_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (expire && (err_cnt != {ERR_WIDTH{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (done_hit) begin
                res_valid <= 1'b1;
            end else if ((state == HOLD) && bus.res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign s1_res = {bus.s1_square_two, bus.s1_square_one, bus.s1_half_two,
                     bus.s1_half_one, bus.s1_out_two, bus.s1_out_one};

    // Results stay put after hand-off; only a new capture replaces them.
    stage_1_result_reg #(
        .W (FLT_DATA_WIDTH)
    ) u_result_reg (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .load   (done_hit),
        .clear  (1'b0),
        .d      (s1_res),
        .q      (res_q)
    );

    assign bus.s1_x_one       = x_one;
    assign bus.s1_x_two       = x_two;
    assign bus.res_valid      = res_valid;
    assign bus.res_out_one    = res_q[0];
    assign bus.res_out_two    = res_q[1];
    assign bus.res_half_one   = res_q[2];
    assign bus.res_half_two   = res_q[3];
    assign bus.res_square_one = res_q[4];
    assign bus.res_square_two = res_q[5];
    assign bus.timeout        = timeout;
    assign bus.err_count      = err_cnt;

endmodule

// File: tb/tb_stage_1_dispatcher.sv
// tb/tb_stage_1_dispatcher.sv - self-checking bench for stage_1_dispatcher
module tb_stage_1_dispatcher;
    import stage_1_dispatcher_pkg::*;

    localparam int W     = FLT_DATA_WIDTH;
    localparam int TO    = 64;
    localparam int EW    = 8;
    localparam int NEVER = 1000;
    localparam int NVEC  = 7;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic clk_en = 1'b0;
    always #5 clk = ~clk;

    stage_1_dispatcher_if #(.W(W), .EW(EW)) bus ();

    stage_1_dispatcher #(
        .FLT_DATA_WIDTH (W),
        .TIMEOUT_CYCLES (TO),
        .ERR_WIDTH      (EW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    typedef logic [5:0][W-1:0] res_t;

    // d = number of WAIT cycles before done (>= TO means done never arrives in time)
    // rdy = cycles res_ready is held low after res_valid; -1 = ready raised early
    typedef struct {
        logic [W-1:0] x1;
        logic [W-1:0] x2;
        int           d;
        int           rdy;
        res_t         v;
        bit           exp_cap;
        int           exp_err;
    } vec_t;

    vec_t vecs [NVEC];

    int   n_vec   = 0;
    int   n_err   = 0;
    int   exp_err = 0;
    int   starts;
    int   rd;
    int   rr;
    bit   bad;
    bit   cap;
    res_t vals;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic res_t rand_vals();
        res_t r;
        for (int i = 0; i < 6; i++) r[i] = $urandom;
        return r;
    endfunction

    function automatic res_t read_res();
        return {bus.res_square_two, bus.res_square_one, bus.res_half_two,
                bus.res_half_one, bus.res_out_two, bus.res_out_one};
    endfunction

    task automatic set_s1(input res_t v);
        bus.s1_out_one    = v[0];
        bus.s1_out_two    = v[1];
        bus.s1_half_one   = v[2];
        bus.s1_half_two   = v[3];
        bus.s1_square_one = v[4];
        bus.s1_square_two = v[5];
    endtask

    task automatic check_res(input res_t v);
        chk("res_out_one",    bus.res_out_one,    v[0]);
        chk("res_out_two",    bus.res_out_two,    v[1]);
        chk("res_half_one",   bus.res_half_one,   v[2]);
        chk("res_half_two",   bus.res_half_two,   v[3]);
        chk("res_square_one", bus.res_square_one, v[4]);
        chk("res_square_two", bus.res_square_two, v[5]);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready,  1'b1);
        chk({tag, "_busy"},      bus.busy,      1'b0);
        chk({tag, "_s1_start"},  bus.s1_start,  1'b0);
        chk({tag, "_res_valid"}, bus.res_valid, 1'b0);
        chk({tag, "_timeout"},   bus.timeout,   1'b0);
        chk({tag, "_err_count"}, bus.err_count, 0);
        chk({tag, "_x_one"},     bus.s1_x_one,  0);
        chk({tag, "_x_two"},     bus.s1_x_two,  0);
        chk({tag, "_res"},       read_res(),    0);
    endtask

    // One full pair transaction, called at a negedge with the DUT in LOAD_ONE.
    task automatic run_pair(input logic [W-1:0] x1, input logic [W-1:0] x2, input int d,
                            input int rdy, input res_t v, input bit exp_cap, input int exp_err_after);
        bit q;
        bus.in_valid = 1'b1;
        bus.in_data  = x1;
        @(negedge clk);
        bus.in_data  = x2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        chk("s1_start",      bus.s1_start, 1'b1);
        chk("s1_x_one",      bus.s1_x_one, x1);
        chk("s1_x_two",      bus.s1_x_two, x2);
        chk("in_ready_fire", bus.in_ready, 1'b0);
        bus.s1_done   = 1'b1;
        set_s1(rand_vals());
        bus.res_ready = (rdy < 0);
        @(negedge clk);
        bus.s1_done = 1'b0;
        q = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (bus.s1_start !== 1'b0 || bus.timeout !== 1'b0 || bus.busy !== 1'b1 ||
                bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
                bus.s1_x_one !== x1 || bus.s1_x_two !== x2) q = 1'b1;
            if (k == d) begin
                bus.s1_done = 1'b1;
                set_s1(v);
                @(negedge clk);
                bus.s1_done = 1'b0;
                set_s1(rand_vals());
                break;
            end
            set_s1(rand_vals());
            @(negedge clk);
        end
        chk("wait_quiet", q, 1'b0);
        if (exp_cap) begin
            chk("res_valid",          bus.res_valid, 1'b1);
            chk("timeout_on_capture", bus.timeout,   1'b0);
            chk("in_ready_hold",      bus.in_ready,  1'b0);
            check_res(v);
            if (rdy > 0) begin
                q = 1'b0;
                for (int i = 0; i < rdy; i++) begin
                    @(negedge clk);
                    if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || read_res() !== v) q = 1'b1;
                end
                chk("hold_stable", q, 1'b0);
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
            chk("res_valid_after_hs", bus.res_valid, 1'b0);
            chk("in_ready_after_hs",  bus.in_ready,  1'b1);
        end else begin
            chk("timeout_pulse",     bus.timeout,   1'b1);
            chk("in_ready_after_to", bus.in_ready,  1'b1);
            chk("res_valid_to",      bus.res_valid, 1'b0);
            @(negedge clk);
            chk("timeout_width",     bus.timeout,   1'b0);
        end
        chk("err_count", bus.err_count, exp_err_after);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.s1_done   = 1'b0;
        bus.res_ready = 1'b0;
        set_s1('0);
        clk_en = 1'b1;

        vecs[0] = '{FLT_ONE, FLT_TWO, 3, 0,
                    {32'h66666666, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    1'b1, 0};
        vecs[1] = '{FLT_HALF, FLT_NEG_ONE, 0, 10, rand_vals(), 1'b1, 0};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, NEVER, 0, rand_vals(), 1'b0, 1};
        vecs[3] = '{FLT_TWO, FLT_ONE, 5, -1, rand_vals(), 1'b1, 1};
        vecs[4] = '{32'hDEADBEEF, 32'h0BADF00D, TO - 1, 2, rand_vals(), 1'b1, 1};
        vecs[5] = '{32'hCAFEF00D, 32'h01234567, TO, 0, rand_vals(), 1'b0, 2};
        vecs[6] = '{FLT_ZERO, 32'hFFFFFFFF, TO - 2, 0, rand_vals(), 1'b1, 2};

        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_pair(vecs[i].x1, vecs[i].x2, vecs[i].d, vecs[i].rdy, vecs[i].v,
                     vecs[i].exp_cap, vecs[i].exp_err);
        end
        exp_err = vecs[NVEC-1].exp_err;

        // clk_en dropped for 3 cycles in FIRE, then during WAIT and HOLD
        bus.in_valid = 1'b1;
        bus.in_data  = FLT_HALF;
        @(negedge clk);
        bus.in_data  = FLT_NEG_ONE;
        @(negedge clk);
        bus.in_valid = 1'b0;
        starts = int'(bus.s1_start);
        clk_en = 1'b0;
        bad    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            bus.s1_done  = 1'b1;
            @(negedge clk);
            starts += int'(bus.s1_start);
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.s1_x_one !== FLT_HALF || bus.s1_x_two !== FLT_NEG_ONE) bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        bus.s1_done  = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        starts += int'(bus.s1_start);
        chk("gated_start_cycles", starts, 4);
        chk("gated_state_data",   bad,    1'b0);
        vals = rand_vals();
        set_s1(vals);
        bus.s1_done = 1'b1;
        clk_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("gated_no_capture", bus.res_valid, 1'b0);
        clk_en = 1'b1;
        @(negedge clk);
        bus.s1_done = 1'b0;
        set_s1(rand_vals());
        chk("gated_capture", bus.res_valid, 1'b1);
        check_res(vals);
        bus.res_ready = 1'b1;
        clk_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("gated_no_handshake", bus.res_valid, 1'b1);
        clk_en = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("gated_handshake",   bus.res_valid, 1'b0);
        chk("gated_in_ready",    bus.in_ready,  1'b1);
        chk("gated_err_count",   bus.err_count, exp_err);

        // Randomized pairs against the transaction-level model:
        // done within TIMEOUT_CYCLES wait cycles is captured, otherwise one timeout.
        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 3))
                0:       rd = $urandom_range(0, 4);
                1:       rd = $urandom_range(TO - 3, TO + 2);
                2:       rd = $urandom_range(5, TO - 4);
                default: rd = NEVER;
            endcase
            rr  = int'($urandom_range(0, 5)) - 1;
            cap = (rd < TO);
            if (!cap && exp_err < (1 << EW) - 1) exp_err++;
            run_pair($urandom, $urandom, rd, rr, rand_vals(), cap, exp_err);
        end

        // Reset while waiting, then a late done that must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom | 32'h1;
        @(negedge clk);
        bus.in_data  = $urandom | 32'h1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_idle("rst_mid");
        exp_err = 0;
        @(negedge clk);
        rst = 1'b1;
        bus.s1_done = 1'b1;
        set_s1(rand_vals());
        repeat (2) @(negedge clk);
        bus.s1_done = 1'b0;
        chk("late_done_res_valid", bus.res_valid, 1'b0);
        chk("late_done_busy",      bus.busy,      1'b0);
        chk("late_done_start",     bus.s1_start,  1'b0);

        run_pair(FLT_ONE, FLT_TWO, 1, 1, rand_vals(), 1'b1, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stage_1_dispatcher.md
# stage_1_dispatcher

Front-end sequencer for the final-adder pipeline. It accepts a stream of single-precision operands over a valid/ready interface and pairs them into x_one/x_two. It issues the start pulse to the stage-1 block and waits for that block's done pulse. It then captures the six stage-1 results and holds them on a valid/ready output until the downstream consumer takes them. It is the initiator side of the stage-1 start/done handshake and carries a timeout so that a missing done cannot hang the pipeline.

## Interface
- FLT_DATA_WIDTH, 32, operand/result width (IEEE-754 single)
- TIMEOUT_CYCLES, 64, maximum number of enabled cycles to wait for s1_done
- ERR_WIDTH, 8, width of the saturating timeout counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clk_en  in  1  global enable; when low, all registers hold and no handshake completes
- in_valid / in_ready  in / out  1 / 1  operand handshake
- in_data  in  FLT_DATA_WIDTH  operand; the first accepted beat is x_one, the second is x_two
- s1_start  out  1  one-cycle start pulse to stage 1
- s1_x_one, s1_x_two  out  FLT_DATA_WIDTH  operands to stage 1, stable from the start pulse until the result is captured
- s1_done  in  1  completion pulse from stage 1
- s1_out_one, s1_out_two, s1_half_one, s1_half_two, s1_square_one, s1_square_two  in  FLT_DATA_WIDTH  stage-1 results, valid when s1_done is high
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_out_one, res_out_two, res_half_one, res_half_two, res_square_one, res_square_two  out  FLT_DATA_WIDTH  registered copies of the stage-1 results
- timeout  out  1  one-cycle pulse when a wait is abandoned
- err_count  out  ERR_WIDTH  number of timeouts, saturating
- busy  out  1  high in every state except LOAD_ONE

## Operation
- States: LOAD_ONE, LOAD_TWO, FIRE, WAIT, HOLD. The state is 3 bits wide and resets to LOAD_ONE.
- A transfer completes only on a clock edge with clk_en=1.
- in_ready is decoded combinationally from the state: high in LOAD_ONE and LOAD_TWO, otherwise low.
- LOAD_ONE: on an accepted beat, latch in_data into s1_x_one and go to LOAD_TWO.
- LOAD_TWO: on an accepted beat, latch in_data into s1_x_two and go to FIRE.
- FIRE: s1_start is high for this cycle only. Clear the wait counter and go to WAIT.
- WAIT:
  - If s1_done=1, capture all six results into the res_* registers, set res_valid and go to HOLD.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no done, pulse timeout, increment err_count (saturating at all-ones), discard the pair and go to LOAD_ONE.
- s1_done is ignored in every state except WAIT. A done in the same cycle as the final timeout count wins: the result is captured and no timeout is raised.
- HOLD: res_* and res_valid stay stable while res_ready=0. On res_valid&res_ready, clear res_valid and go to LOAD_ONE.
- Reset values: state LOAD_ONE, every output register 0, res_valid 0, s1_start 0, timeout 0, err_count 0, wait counter 0.
- A reset asserted mid-operation abandons any pair or result immediately and emits no start or timeout pulse.
- No arithmetic on data; all values are passed bit-exact.

## Timing
- Edges are enabled edges. The second operand is accepted at edge N.
- s1_start is high during cycle N+1, and WAIT is entered at N+2.
- If s1_done is sampled high at edge M, res_valid is high from M+1.
- Best case from second operand to res_valid is 3 cycles, with s1_done high in the first WAIT cycle.
- res_ready is allowed to be high before res_valid. The handshake completes at the first edge where both are high, and in_ready rises the cycle after.
- Throughput is at most one pair per 5 cycles; there is no overlap of pairs.
- With clk_en=0, every output holds its value, including s1_start and timeout. The pulses stretch; this is intended, because stage 1 uses the same clk_en.

## Structure
- A shared package holds the state encodings (3-bit localparams LOAD_ONE=0 … HOLD=4), FLT_DATA_WIDTH, and the canonical float constants used by the benches.
- One sub-module: stage_1_result_reg, a 6×FLT_DATA_WIDTH capture register with load and clear, used for the res_* bank.

## Test plan
- Basic pair:
  - Stimulus: in_data 0x3F800000 then 0x40000000; stub returns done 4 cycles after start with the out/half/square pairs set to 0x11111111…0x66666666.
  - Response: one s1_start pulse with s1_x_one=0x3F800000 and s1_x_two=0x40000000; res_* match the stub values; res_valid high until res_ready.
- Backpressure: hold res_ready=0 for 10 cycles -> res_* stable, in_ready=0 throughout; in_ready=1 the cycle after the handshake.
- Timeout: the stub never asserts done -> timeout pulses TIMEOUT_CYCLES cycles after WAIT entry; err_count=1; the next pair processes normally.
- Done on the boundary: done arrives on the final timeout cycle -> result captured, no timeout pulse, err_count unchanged.
- clk_en gating: drop clk_en for 3 cycles during FIRE -> s1_start is high for 4 cycles total; state and data are unchanged; exactly one stage-1 operation completes.
- Reset mid-WAIT: assert rst low while waiting -> all outputs 0 asynchronously and state LOAD_ONE; a late done is ignored.
